// File: rtl/riscv_dcache_mem_bridge.sv
// riscv_dcache_mem_bridge: splits D-cache line refill/writeback requests into
// BUS_WIDTH beats on a valid/ready request bus and rebuilds refill lines.
// Ports:
//   i_riscv_dcache_clk / i_riscv_dcache_rst : clock, async active-high reset
//   i_bridge_wren/rden/addr/wdata           : cache-side line request (held)
//   o_bridge_ready/rdata/err                : completion pulse, refill line, timeout
//   o_bus_req_valid/i_bus_req_ready         : beat request handshake
//   o_bus_we/addr/wdata                     : beat direction, byte address, write data
//   i_bus_rsp_valid/i_bus_rdata             : in-order read response beats
// Optional: define RISCV_DCACHE_BRIDGE_TIMEOUT_EN for the bus watchdog.

module riscv_dcache_mem_bridge #(
    parameter int DATA_WIDTH     = 128,
    parameter int BUS_WIDTH      = 32,
    parameter int S_ADDR         = 23,
    parameter int BEATS          = DATA_WIDTH / BUS_WIDTH,
    parameter int BADDR          = S_ADDR + $clog2(DATA_WIDTH / 8),
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  i_riscv_dcache_clk,
    input  logic                  i_riscv_dcache_rst,
    input  logic                  i_bridge_wren,
    input  logic                  i_bridge_rden,
    input  logic [S_ADDR-1:0]     i_bridge_addr,
    input  logic [DATA_WIDTH-1:0] i_bridge_wdata,
    output logic                  o_bridge_ready,
    output logic [DATA_WIDTH-1:0] o_bridge_rdata,
    output logic                  o_bridge_err,
    output logic                  o_bus_req_valid,
    input  logic                  i_bus_req_ready,
    output logic                  o_bus_we,
    output logic [BADDR-1:0]      o_bus_addr,
    output logic [BUS_WIDTH-1:0]  o_bus_wdata,
    input  logic                  i_bus_rsp_valid,
    input  logic [BUS_WIDTH-1:0]  i_bus_rdata
);

    localparam int IW   = $clog2(BEATS);
    localparam int BOFF = $clog2(BUS_WIDTH / 8);
    localparam logic [IW-1:0] LAST = IW'(BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_RD, S_DONE, S_GAP
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [S_ADDR-1:0]     r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_line;
    logic [IW-1:0]         r_idx;
    logic [IW-1:0]         r_rsp_idx;
    logic                  r_req_done;

    logic                  w_req_hs;
    logic                  w_rsp;
    logic                  w_start;
    logic                  w_timeout;
    logic [BADDR-1:0]      w_addr;

    assign w_req_hs = o_bus_req_valid & i_bus_req_ready;
    // Responses only count while a refill is in flight.
    assign w_rsp    = (r_state == S_RD) & i_bus_rsp_valid;
    assign w_start  = (r_state == S_IDLE) & (i_bridge_wren | i_bridge_rden);
    assign w_addr   = {r_addr, {(BADDR - S_ADDR){1'b0}}}
                    | (BADDR'(r_idx) << BOFF);

`ifdef RISCV_DCACHE_BRIDGE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic [TW-1:0] r_to_cnt;
    logic          r_err;
    logic          w_busy;

    assign w_busy    = (r_state == S_WR) | (r_state == S_RD);
    assign w_timeout = w_busy & (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Any bus activity proves the slave is alive and restarts the watchdog.
    always_ff @(posedge i_riscv_dcache_clk or posedge i_riscv_dcache_rst) begin
        if (i_riscv_dcache_rst) begin
            r_to_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            r_err <= w_timeout;
            if (!w_busy || w_req_hs || w_rsp)
                r_to_cnt <= '0;
            else
                r_to_cnt <= r_to_cnt + TW'(1);
        end
    end

    assign o_bridge_err = (r_state == S_DONE) & r_err;
`else
    assign w_timeout    = 1'b0;
    assign o_bridge_err = 1'b0;
`endif

    // State register
    always_ff @(posedge i_riscv_dcache_clk or posedge i_riscv_dcache_rst) begin
        if (i_riscv_dcache_rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state logic; write has priority over read
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (i_bridge_wren)
                    w_next = S_WR;
                else if (i_bridge_rden)
                    w_next = S_RD;
            end
            S_WR:   if (w_req_hs && r_idx == LAST) w_next = S_DONE;
            S_RD:   if (w_rsp && r_rsp_idx == LAST) w_next = S_DONE;
            S_DONE: w_next = S_GAP;
            S_GAP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (w_timeout)
            w_next = S_DONE;
    end

    // Outputs; beat fields are zero whenever no request is presented
    always_comb begin
        o_bus_req_valid = (r_state == S_WR)
                        | ((r_state == S_RD) & ~r_req_done);
        o_bus_we        = (r_state == S_WR);
        o_bus_addr      = o_bus_req_valid ? w_addr : '0;
        o_bus_wdata     = '0;
        if (r_state == S_WR)
            o_bus_wdata = r_wdata[r_idx*BUS_WIDTH +: BUS_WIDTH];
        o_bridge_ready  = (r_state == S_DONE);
        o_bridge_rdata  = r_line;
    end

    // Datapath: request latch, beat counters, line assembly
    always_ff @(posedge i_riscv_dcache_clk or posedge i_riscv_dcache_rst) begin
        if (i_riscv_dcache_rst) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_line     <= '0;
            r_idx      <= '0;
            r_rsp_idx  <= '0;
            r_req_done <= 1'b0;
        end else begin
            if (w_start) begin
                r_addr     <= i_bridge_addr;
                r_wdata    <= i_bridge_wdata;
                r_idx      <= '0;
                r_rsp_idx  <= '0;
                r_req_done <= 1'b0;
            end
            if (w_req_hs) begin
                r_idx <= r_idx + IW'(1);
                // Read requests stop after the last beat; writes leave via DONE.
                if (r_idx == LAST)
                    r_req_done <= 1'b1;
            end
            if (w_rsp) begin
                r_line[r_rsp_idx*BUS_WIDTH +: BUS_WIDTH] <= i_bus_rdata;
                r_rsp_idx <= r_rsp_idx + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_riscv_dcache_mem_bridge.sv
// tb_riscv_dcache_mem_bridge: randomized bench with a line-level reference model
// and a bus slave with configurable backpressure and response delay.

module tb_riscv_dcache_mem_bridge;

    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_bridge_wren, i_bridge_rden;
    logic [22:0]   i_bridge_addr;
    logic [127:0]  i_bridge_wdata;
    logic          o_bridge_ready, o_bridge_err;
    logic [127:0]  o_bridge_rdata;
    logic          o_bus_req_valid, o_bus_we;
    logic          i_bus_req_ready = 1'b0;
    logic [26:0]   o_bus_addr;
    logic [31:0]   o_bus_wdata;
    logic          i_bus_rsp_valid = 1'b0;
    logic [31:0]   i_bus_rdata = 32'h0;

    riscv_dcache_mem_bridge dut (
        .i_riscv_dcache_clk (clk),
        .i_riscv_dcache_rst (rst),
        .i_bridge_wren      (i_bridge_wren),
        .i_bridge_rden      (i_bridge_rden),
        .i_bridge_addr      (i_bridge_addr),
        .i_bridge_wdata     (i_bridge_wdata),
        .o_bridge_ready     (o_bridge_ready),
        .o_bridge_rdata     (o_bridge_rdata),
        .o_bridge_err       (o_bridge_err),
        .o_bus_req_valid    (o_bus_req_valid),
        .i_bus_req_ready    (i_bus_req_ready),
        .o_bus_we           (o_bus_we),
        .o_bus_addr         (o_bus_addr),
        .o_bus_wdata        (o_bus_wdata),
        .i_bus_rsp_valid    (i_bus_rsp_valid),
        .i_bus_rdata        (i_bus_rdata)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model state (written by the stimulus process only)
    int           txn_id = 0;
    bit           active = 1'b0;
    bit           exp_we = 1'b0;
    logic [22:0]  exp_addr = '0;
    logic [127:0] exp_wdata = '0;
    logic [127:0] exp_line = '0;
    bit           fixed_mode = 1'b0;
    logic [31:0]  seed = 32'h0;
    int           rdy_mode = 0;
    int           rsp_dly = 0;

    // Memory contents seen by the bus slave, as a function of byte address
    function automatic logic [31:0] memf(input logic [26:0] a);
        logic [31:0] t;
        t = {5'b0, a};
        if (fixed_mode)
            return 32'hDEAD0000 | {30'b0, a[3:2]};
        return (t * 32'h9E3779B1) ^ seed;
    endfunction

    // Compare / bus-slave state (written by the compare process only)
    int           cyc = 0;
    int           seen_txn = 0;
    int           cmp_idx = 0;
    int           ready_cnt = 0;
    int           rsp_cnt = 0;
    int           last_due = 0;
    logic [127:0] last_line = '0;
    bit           prev_stall = 1'b0;
    bit           alt = 1'b0;
    logic         prev_we = 1'b0;
    logic [26:0]  prev_addr = '0;
    logic [31:0]  prev_wdata = '0;
    logic [31:0]  q_data[$];
    int           q_due[$];
    logic [26:0]  log_addr[NB];
    logic [31:0]  log_data[NB];

    always @(negedge clk) begin
        logic        hs;
        logic [26:0] ea;
        int          d, due;
        cyc++;
        if (seen_txn != txn_id) begin
            seen_txn = txn_id;
            cmp_idx  = 0;
        end
        if (rst) begin
            last_line  = '0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", o_bus_req_valid, 1);
                chk("hold_we", o_bus_we, prev_we);
                chk("hold_addr", o_bus_addr, prev_addr);
                chk("hold_wdata", o_bus_wdata, prev_wdata);
            end
            if (o_bus_req_valid) begin
                if (!active || cmp_idx >= NB) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL stray_beat: got beat %0d active %0d expected none",
                             cmp_idx, active);
                end else begin
                    ea = {exp_addr, 4'h0} + 27'(cmp_idx * 4);
                    chk("beat_we", o_bus_we, exp_we);
                    chk("beat_addr", o_bus_addr, ea);
                    if (exp_we)
                        chk("beat_wdata", o_bus_wdata,
                            exp_wdata[cmp_idx*32 +: 32]);
                end
            end
            if (o_bridge_ready) begin
                ready_cnt++;
                if (!active) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL stray_ready: got ready=1 expected 0");
                end else begin
                    chk("beat_count", cmp_idx, NB);
                    chk("err_flag", o_bridge_err, 0);
                    if (exp_we) begin
                        chk("rdata_kept", o_bridge_rdata, last_line);
                    end else begin
                        chk("rdata_line", o_bridge_rdata, exp_line);
                        last_line = exp_line;
                    end
                end
            end
        end
        case (rdy_mode)
            0: i_bus_req_ready = 1'b1;
            1: begin
                i_bus_req_ready = alt;
                alt = ~alt;
            end
            2: i_bus_req_ready = 1'($urandom_range(0, 1));
            default: i_bus_req_ready = 1'b0;
        endcase
        hs = o_bus_req_valid && i_bus_req_ready;
        if (hs) begin
            if (cmp_idx < NB) begin
                log_addr[cmp_idx] = o_bus_addr;
                log_data[cmp_idx] = o_bus_wdata;
            end
            cmp_idx++;
            if (!o_bus_we) begin
                d   = (rsp_dly < 0) ? $urandom_range(0, 3) : rsp_dly;
                due = cyc + 1 + d;
                if (due <= last_due)
                    due = last_due + 1;
                last_due = due;
                q_data.push_back(memf(o_bus_addr));
                q_due.push_back(due);
            end
        end
        prev_stall = o_bus_req_valid && !i_bus_req_ready;
        prev_we    = o_bus_we;
        prev_addr  = o_bus_addr;
        prev_wdata = o_bus_wdata;
        if (q_due.size() > 0 && q_due[0] <= cyc) begin
            i_bus_rsp_valid = 1'b1;
            i_bus_rdata     = q_data.pop_front();
            void'(q_due.pop_front());
            rsp_cnt++;
        end else begin
            i_bus_rsp_valid = 1'b0;
            i_bus_rdata     = $urandom;
        end
    end

    task automatic start(input bit we, input bit rd, input logic [22:0] a,
                         input logic [127:0] wd);
        txn_id++;
        exp_we    = we;
        exp_addr  = a;
        exp_wdata = wd;
        for (int i = 0; i < NB; i++)
            exp_line[i*32 +: 32] = memf({a, 4'h0} + 27'(i * 4));
        active         = 1'b1;
        i_bridge_wren  = we;
        i_bridge_rden  = rd;
        i_bridge_addr  = a;
        i_bridge_wdata = wd;
    endtask

    task automatic wait_done(output int cycles);
        int r0;
        r0 = ready_cnt;
        cycles = 0;
        while (1) begin
            @(negedge clk);
            #2;
            cycles++;
            if (ready_cnt != r0)
                break;
            if (cycles > 300) begin
                vectors++;
                miscompares++;
                $display("FAIL ready_timeout: got no ready in %0d cycles expected one",
                         cycles);
                break;
            end
        end
    endtask

    task automatic finish_txn();
        i_bridge_wren = 1'b0;
        i_bridge_rden = 1'b0;
        active        = 1'b0;
    endtask

    task automatic run_txn(input bit we, input logic [22:0] a,
                           input logic [127:0] wd, output int cycles);
        start(we, !we, a, wd);
        wait_done(cycles);
        finish_txn();
    endtask

    // Both requests high: the write runs first, then the held read.
    task automatic run_both(input logic [22:0] a, input logic [127:0] wd,
                            output int cycles);
        int c1;
        start(1'b1, 1'b1, a, wd);
        wait_done(c1);
        txn_id++;
        exp_we        = 1'b0;
        i_bridge_wren = 1'b0;
        wait_done(cycles);
        finish_txn();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    initial begin
        int           cycles, r0, c0;
        logic [26:0]  la[NB];
        logic [31:0]  ld[NB];
        logic [127:0] wd;
        rst            = 1'b1;
        i_bridge_wren  = 1'b0;
        i_bridge_rden  = 1'b0;
        i_bridge_addr  = '0;
        i_bridge_wdata = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_outputs", {o_bridge_ready, o_bridge_err, o_bus_req_valid,
            o_bus_we, o_bus_addr, o_bus_wdata}, 0);
        chk("reset_rdata", o_bridge_rdata, 0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        idle(1);

        // Directed write, bus always ready
        la = '{27'h120, 27'h124, 27'h128, 27'h12C};
        ld = '{32'h00000000, 32'h11111111, 32'h22222222, 32'h33333333};
        r0 = ready_cnt;
        run_txn(1'b1, 23'h000012,
                128'h33333333_22222222_11111111_00000000, cycles);
        chk("wr_latency", cycles, 5);
        for (int i = 0; i < NB; i++) begin
            chk("t1_addr", log_addr[i], la[i]);
            chk("t1_data", log_data[i], ld[i]);
        end
        idle(3);
        chk("t1_one_pulse", ready_cnt - r0, 1);

        // Directed reads with fixed data, immediate then delayed responses
        fixed_mode = 1'b1;
        run_txn(1'b0, 23'h000005, '0, cycles);
        chk("rd_latency", cycles, 6);
        chk("rd_line_lit", o_bridge_rdata,
            128'hDEAD0003_DEAD0002_DEAD0001_DEAD0000);
        idle(2);
        rsp_dly = 2;
        r0 = ready_cnt;
        run_txn(1'b0, 23'h7ABCDE, '0, cycles);
        chk("rd_dly_line_lit", o_bridge_rdata,
            128'hDEAD0003_DEAD0002_DEAD0001_DEAD0000);
        idle(3);
        chk("t2_one_pulse", ready_cnt - r0, 1);

        // Alternating backpressure during a write
        fixed_mode = 1'b0;
        seed       = $urandom;
        rdy_mode   = 1;
        r0 = ready_cnt;
        wd = {$urandom, $urandom, $urandom, $urandom};
        run_txn(1'b1, 23'h00ABCD, wd, cycles);
        idle(3);
        chk("bp_one_pulse", ready_cnt - r0, 1);
        chk("rdata_after_wr", o_bridge_rdata,
            128'hDEAD0003_DEAD0002_DEAD0001_DEAD0000);

        // wren and rden together: write, ready, gap, then read
        rdy_mode = 0;
        rsp_dly  = 0;
        wd = {$urandom, $urandom, $urandom, $urandom};
        run_both(23'h01F00F, wd, cycles);
        chk("wr_then_rd_lat", cycles, 8);
        idle(2);

        // Reset in the middle of a read after two responses
        seed    = $urandom;
        rsp_dly = 2;
        c0 = rsp_cnt;
        start(1'b0, 1'b1, 23'h002468, '0);
        for (int k = 0; k < 50 && rsp_cnt - c0 < 2; k++) begin
            @(negedge clk);
            #2;
        end
        chk("two_responses", rsp_cnt - c0, 2);
        @(posedge clk);
        #1;
        rst = 1'b1;
        finish_txn();
        #1;
        chk("midrst_outputs", {o_bridge_ready, o_bridge_err, o_bus_req_valid,
            o_bus_we, o_bus_addr, o_bus_wdata}, 0);
        chk("midrst_rdata", o_bridge_rdata, 0);
        r0 = ready_cnt;
        @(negedge clk);
        #2;
        rst = 1'b0;
        idle(8);
        chk("no_ready_after_rst", ready_cnt - r0, 0);
        chk("rdata_after_rst", o_bridge_rdata, 0);
        run_txn(1'b0, 23'h013579, '0, cycles);
        idle(1);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            int op;
            logic [22:0] a;
            op       = $urandom_range(0, 2);
            rdy_mode = $urandom_range(0, 2);
            rsp_dly  = ($urandom_range(0, 1) == 1) ? -1 : $urandom_range(0, 3);
            seed     = $urandom;
            a        = 23'($urandom);
            wd       = {$urandom, $urandom, $urandom, $urandom};
            if (op == 2)
                run_both(a, wd, cycles);
            else
                run_txn(op == 0, a, wd, cycles);
            idle($urandom_range(0, 2));
        end
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
